// File: rtl/imm_gen_pipe.sv
// RISC-V immediate extractor for decode: 1-cycle latency, full throughput.
// Backpressure absorbed by the output register plus one skid entry; in_ready depends on state only.
module imm_gen_pipe #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 8,
  parameter int SRC_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [SRC_W-1:0] in_imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  if (XLEN != 32 && XLEN != 64) begin : g_xlen_chk
    $error("imm_gen_pipe: XLEN must be 32 or 64");
  end

  localparam logic [SRC_W-1:0] SEL_I  = SRC_W'(0);
  localparam logic [SRC_W-1:0] SEL_S  = SRC_W'(1);
  localparam logic [SRC_W-1:0] SEL_B  = SRC_W'(2);
  localparam logic [SRC_W-1:0] SEL_U  = SRC_W'(3);
  localparam logic [SRC_W-1:0] SEL_J  = SRC_W'(4);
  localparam logic [SRC_W-1:0] SEL_Z  = SRC_W'(5);
  localparam logic [SRC_W-1:0] SEL_SH = SRC_W'(6);

  typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_FULL} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              w_acc;
  logic              w_drain;
  logic              w_load_out_new;
  logic              w_load_out_skid;
  logic              w_load_skid;
  logic [31:0]       w_imm32;
  logic              w_ill;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   r_out_imm;
  logic [TAG_W-1:0]  r_out_tag;
  logic              r_out_ill;
  logic [XLEN-1:0]   r_skid_imm;
  logic [TAG_W-1:0]  r_skid_tag;
  logic              r_skid_ill;

  // Every format fits in 32 bits with its sign in bit 31; zero-extended ones keep bit 31 clear.
  always_comb begin
    w_imm32 = '0;
    w_ill   = 1'b0;
    case (in_imm_src)
      SEL_I:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      SEL_S:  w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      SEL_B:  w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                         in_instr[11:8], 1'b0};
      SEL_U:  w_imm32 = {in_instr[31:12], 12'b0};
      SEL_J:  w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                         in_instr[30:21], 1'b0};
      SEL_Z:  w_imm32 = {27'b0, in_instr[19:15]};
      SEL_SH: begin
        if (XLEN == 64) begin
          w_imm32 = {26'b0, in_instr[25:20]};
        end else begin
          w_imm32 = {27'b0, in_instr[24:20]};
          w_ill   = in_instr[25];
        end
      end
      default: w_ill = 1'b1;
    endcase
  end

  assign w_imm = XLEN'($signed(w_imm32));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_EMPTY: if (w_acc) w_next = ST_ONE;
      ST_ONE: begin
        if (w_acc && !w_drain)      w_next = ST_FULL;
        else if (!w_acc && w_drain) w_next = ST_EMPTY;
      end
      ST_FULL:  if (w_drain) w_next = ST_ONE;
      default:  w_next = ST_EMPTY;
    endcase
  end

  always_comb begin
    in_ready        = (r_state != ST_FULL);
    out_valid       = (r_state != ST_EMPTY);
    w_acc           = in_valid && in_ready;
    w_drain         = out_valid && out_ready;
    w_load_out_new  = w_acc && ((r_state == ST_EMPTY) || (r_state == ST_ONE && w_drain));
    w_load_skid     = w_acc && (r_state == ST_ONE) && !w_drain;
    w_load_out_skid = (r_state == ST_FULL) && w_drain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_imm  <= '0;
      r_out_tag  <= '0;
      r_out_ill  <= 1'b0;
      r_skid_imm <= '0;
      r_skid_tag <= '0;
      r_skid_ill <= 1'b0;
    end else begin
      if (w_load_out_new) begin
        r_out_imm <= w_imm;
        r_out_tag <= in_tag;
        r_out_ill <= w_ill;
      end else if (w_load_out_skid) begin
        r_out_imm <= r_skid_imm;
        r_out_tag <= r_skid_tag;
        r_out_ill <= r_skid_ill;
      end
      if (w_load_skid) begin
        r_skid_imm <= w_imm;
        r_skid_tag <= in_tag;
        r_skid_ill <= w_ill;
      end
    end
  end

  assign out_imm     = r_out_imm;
  assign out_tag     = r_out_tag;
  assign out_illegal = r_out_ill;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: occupancy/FIFO reference model checked every cycle,
// plus directed vectors with literal expectations on XLEN=64 and XLEN=32 instances.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr;
  logic [2:0]  in_imm_src;
  logic [7:0]  in_tag, out_tag;
  logic [63:0] out_imm;

  logic        v32, r32, ov32, ordy32, ill32;
  logic [31:0] instr32, imm32;
  logic [2:0]  src32;
  logic [7:0]  tag32, otag32;

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SRC_W(3)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_imm_src(in_imm_src), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_tag(out_tag), .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SRC_W(3)) u_dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(v32), .in_ready(r32),
    .in_instr(instr32), .in_imm_src(src32), .in_tag(tag32),
    .out_valid(ov32), .out_ready(ordy32), .out_imm(imm32),
    .out_tag(otag32), .out_illegal(ill32)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Reference decode: pull the scattered fields out arithmetically, then apply two's complement.
  function automatic void ref_dec(input logic [31:0] ins, input int src, input int xl,
                                  output logic [63:0] imm, output logic ill);
    longint u, v;
    int n;
    u = longint'({32'b0, ins});
    v = 0;
    n = 0;
    ill = 1'b0;
    case (src)
      0: begin v = u >> 20; n = 12; end
      1: begin v = ((u >> 25) << 5) | ((u >> 7) & 31); n = 12; end
      2: begin
        v = ((u >> 31) << 12) | (((u >> 7) & 1) << 11) | (((u >> 25) & 63) << 5) |
            (((u >> 8) & 15) << 1);
        n = 13;
      end
      3: begin v = (u >> 12) << 12; n = 32; end
      4: begin
        v = ((u >> 31) << 20) | (((u >> 12) & 255) << 12) | (((u >> 20) & 1) << 11) |
            (((u >> 21) & 1023) << 1);
        n = 21;
      end
      5: v = (u >> 15) & 31;
      6: begin
        v   = (u >> 20) & ((xl == 64) ? 63 : 31);
        ill = (xl == 32) && (((u >> 25) & 1) == 1);
      end
      default: ill = 1'b1;
    endcase
    if (n > 0 && v >= (longint'(1) << (n - 1))) v = v - (longint'(1) << n);
    imm = 64'(v);
    if (xl == 32) imm[63:32] = '0;
  endfunction

  typedef struct {
    logic [63:0] imm;
    logic [7:0]  tag;
    logic        ill;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          n_acc = 0;
  int          n_rx  = 0;
  logic        prev_hold = 1'b0;
  logic [63:0] prev_imm;
  logic [7:0]  prev_tag;
  logic        prev_ill;

  // Items held by the DUT = items accepted and not yet drained, capacity two.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      check("in_ready_vs_occupancy", 64'(in_ready), 64'(q.size() < 2));
      check("out_valid_vs_occupancy", 64'(out_valid), 64'(q.size() > 0));
      if (prev_hold) begin
        check("hold_imm", out_imm, prev_imm);
        check("hold_tag", 64'(out_tag), 64'(prev_tag));
        check("hold_ill", 64'(out_illegal), 64'(prev_ill));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL stream_extra: got tag %h, expected no output", out_tag);
        end else begin
          e = q.pop_front();
          check("stream_imm", out_imm, e.imm);
          check("stream_tag", 64'(out_tag), 64'(e.tag));
          check("stream_ill", 64'(out_illegal), 64'(e.ill));
          n_rx++;
        end
      end
      if (in_valid && in_ready) begin
        ref_dec(in_instr, int'(in_imm_src), 64, e.imm, e.ill);
        e.tag = in_tag;
        q.push_back(e);
        n_acc++;
      end
      prev_hold = out_valid && !out_ready;
      prev_imm  = out_imm;
      prev_tag  = out_tag;
      prev_ill  = out_illegal;
    end
  end

  task automatic send_one(input string nm, input logic [31:0] ins, input logic [2:0] src,
                          input logic [7:0] tag, input logic [63:0] e_imm, input logic e_ill);
    int k;
    @(posedge clk); #1;
    in_instr = ins; in_imm_src = src; in_tag = tag; in_valid = 1'b1; out_ready = 1'b1;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_accept: got in_ready 0, expected 1 within 20 cycles", nm);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check({nm, "_valid"}, 64'(out_valid), 64'd1);
    check({nm, "_imm"}, out_imm, e_imm);
    check({nm, "_tag"}, 64'(out_tag), 64'(tag));
    check({nm, "_ill"}, 64'(out_illegal), 64'(e_ill));
  endtask

  task automatic send32(input string nm, input logic [31:0] ins, input logic [2:0] src,
                        input logic [7:0] tag, input logic [31:0] e_imm, input logic e_ill);
    @(posedge clk); #1;
    instr32 = ins; src32 = src; tag32 = tag; v32 = 1'b1; ordy32 = 1'b1;
    @(negedge clk);
    check({nm, "_rdy"}, 64'(r32), 64'd1);
    @(posedge clk); #1;
    v32 = 1'b0;
    @(negedge clk);
    check({nm, "_valid"}, 64'(ov32), 64'd1);
    check({nm, "_imm"}, 64'(imm32), 64'(e_imm));
    check({nm, "_tag"}, 64'(otag32), 64'(tag));
    check({nm, "_ill"}, 64'(ill32), 64'(e_ill));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got no finish by 3ms, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   sent, acc0, rx0, k;
    logic w;
    rst_n = 1'b1;
    in_valid = 1'b0; in_instr = '0; in_imm_src = '0; in_tag = '0; out_ready = 1'b0;
    v32 = 1'b0; instr32 = '0; src32 = '0; tag32 = '0; ordy32 = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_imm", out_imm, 64'd0);
    check("rst_out_tag", 64'(out_tag), 64'd0);
    check("rst_out_ill", 64'(out_illegal), 64'd0);
    #19 rst_n = 1'b1;

    send_one("i_neg1", 32'hFFF00093, 3'd0, 8'hA1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_one("s_neg4", 32'hFE112E23, 3'd1, 8'hA2, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_one("b_neg4", 32'hFE000EE3, 3'd2, 8'hA3, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_one("u_neg",  32'h800000B7, 3'd3, 8'hA4, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send_one("j_8",    32'h0080006F, 3'd4, 8'hA5, 64'h8, 1'b0);
    send_one("z_1f",   32'h000F8073, 3'd5, 8'hA6, 64'h1F, 1'b0);
    send_one("sh64",   32'h02100093, 3'd6, 8'hA7, 64'h21, 1'b0);
    send_one("rsvd",   32'hFFFFFFFF, 3'd7, 8'hA8, 64'h0, 1'b1);

    send32("x32_sh",  32'h02100093, 3'd6, 8'h5A, 32'h1, 1'b1);
    send32("x32_i",   32'hFFF00093, 3'd0, 8'h5B, 32'hFFFF_FFFF, 1'b0);
    send32("x32_u",   32'h800000B7, 3'd3, 8'h5C, 32'h8000_0000, 1'b0);

    // Backpressure: three offers with the sink stalled, then release.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_imm_src = 3'd0; in_instr = 32'h00100093; in_tag = 8'd1;
    @(negedge clk); check("bp_rdy_t1", 64'(in_ready), 64'd1);
    @(posedge clk); #1; in_instr = 32'h00200093; in_tag = 8'd2;
    @(negedge clk); check("bp_rdy_t2", 64'(in_ready), 64'd1);
    @(posedge clk); #1; in_instr = 32'h00300093; in_tag = 8'd3;
    @(negedge clk); check("bp_rdy_t3", 64'(in_ready), 64'd0);
    check("bp_hold_tag_a", 64'(out_tag), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); check("bp_rdy_still", 64'(in_ready), 64'd0);
    check("bp_hold_tag_b", 64'(out_tag), 64'd1);
    @(posedge clk); #1; out_ready = 1'b1;
    @(negedge clk); check("bp_seq1", 64'(out_tag), 64'd1);
    @(posedge clk); #1;
    @(negedge clk); check("bp_seq2", 64'(out_tag), 64'd2);
    check("bp_rdy_after", 64'(in_ready), 64'd1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk); check("bp_seq3", 64'(out_tag), 64'd3);
    check("bp_seq3_valid", 64'(out_valid), 64'd1);
    check("bp_seq3_imm", out_imm, 64'd3);
    @(posedge clk); #1;
    @(negedge clk); check("bp_empty", 64'(out_valid), 64'd0);

    // Fill both entries, then reset asynchronously.
    @(posedge clk); #1;
    out_ready = 1'b0; in_valid = 1'b1; in_instr = 32'h00500093; in_tag = 8'h10;
    @(posedge clk); #1; in_tag = 8'h11;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    check("full_rdy", 64'(in_ready), 64'd0);
    check("full_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_out_tag", 64'(out_tag), 64'd0);
    #17 rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_rdy", 64'(in_ready), 64'd1);
    check("post_rst_valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1; out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_out", 64'(out_valid), 64'd0);
    end

    // Random stream.
    acc0 = n_acc;
    rx0  = n_rx;
    sent = 0;
    while (sent < 10000) begin
      @(negedge clk);
      w = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || w) begin
        if ($urandom_range(3) != 0) begin
          in_instr   = $urandom;
          in_imm_src = 3'($urandom_range(7));
          in_tag     = 8'(sent);
          in_valid   = 1'b1;
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(2) != 0);
    end
    k = 0;
    while ((in_valid || q.size() != 0) && k < 200) begin
      @(negedge clk);
      w = in_valid && in_ready;
      @(posedge clk); #1;
      if (w) in_valid = 1'b0;
      out_ready = 1'b1;
      k++;
    end
    @(negedge clk);
    check("rand_accepted", 64'(n_acc - acc0), 64'd10000);
    check("rand_received", 64'(n_rx - rx0), 64'd10000);
    check("rand_drained", 64'(q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
